// File: rtl/vram_pkg.sv
// Shared VRAM definitions: framebuffer geometry, RGBA4441 pixel layout and
// the blitter state encoding.
package vram_pkg;

  localparam int FB_W   = 160;
  localparam int FB_H   = 120;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 13;

  typedef logic [DATA_W-1:0] pixel_t;

  localparam int R_HI  = 12;
  localparam int R_LO  = 9;
  localparam int G_HI  = 8;
  localparam int G_LO  = 5;
  localparam int B_HI  = 4;
  localparam int B_LO  = 1;
  localparam int A_BIT = 0;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} blit_state_t;

  function automatic logic [3:0] pix_r(input pixel_t p);
    return p[R_HI:R_LO];
  endfunction

  function automatic logic [3:0] pix_g(input pixel_t p);
    return p[G_HI:G_LO];
  endfunction

  function automatic logic [3:0] pix_b(input pixel_t p);
    return p[B_HI:B_LO];
  endfunction

  function automatic logic pix_a(input pixel_t p);
    return p[A_BIT];
  endfunction

endpackage

// File: rtl/rect_walker.sv
// Raster walk over a rectangle: column/row counters, last-step flag, and
// the clipped framebuffer address of the current position.
module rect_walker #(
  parameter int FB_W   = vram_pkg::FB_W,
  parameter int FB_H   = vram_pkg::FB_H,
  parameter int ADDR_W = vram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic [7:0]        w,
  input  logic [6:0]        h,
  output logic              last,
  output logic              in_bounds,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [8:0]  FB_W_L = 9'(FB_W);
  localparam logic [7:0]  FB_H_L = 8'(FB_H);
  localparam logic [16:0] FB_W_M = 17'(FB_W);

  logic [7:0]  i;
  logic [6:0]  j;
  logic [8:0]  px;
  logic [7:0]  py;
  logic [16:0] addr_full;
  logic        row_end;

  assign row_end   = (i == w - 8'd1);
  assign last      = row_end && (j == h - 7'd1);
  assign px        = {1'b0, x} + {1'b0, i};
  assign py        = {1'b0, y} + {1'b0, j};
  assign in_bounds = (px < FB_W_L) && (py < FB_H_L);
  // 17 bits covers the largest unclipped-or-not product, then truncate.
  assign addr_full = ({9'd0, py} * FB_W_M) + {8'd0, px};
  assign addr      = addr_full[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
    end else if (start) begin
      i <= '0;
      j <= '0;
    end else if (step) begin
      if (row_end) begin
        i <= '0;
        j <= last ? 7'd0 : j + 7'd1;
      end else begin
        i <= i + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vram_blitter.sv
// Rectangle fill / stream-copy engine writing RGBA4441 words into a VRAM
// write port, optionally restricted to vertical blanking.
module vram_blitter #(
  parameter int FB_W        = vram_pkg::FB_W,
  parameter int FB_H        = vram_pkg::FB_H,
  parameter int ADDR_W      = vram_pkg::ADDR_W,
  parameter int DATA_W      = vram_pkg::DATA_W,
  parameter bit GATE_VBLANK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [7:0]        cmd_x,
  input  logic [6:0]        cmd_y,
  input  logic [7:0]        cmd_w,
  input  logic [6:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  import vram_pkg::*;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready
  // are both high; valid never waits on ready, ready may depend on valid-free
  // state only, and a producer holds its data stable until the transfer.

  blit_state_t       state;
  logic              mode_q;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [7:0]        w_q;
  logic [6:0]        h_q;
  logic [DATA_W-1:0] color_q;

  logic              gate_ok;
  logic              accept;
  logic              step;
  logic              last;
  logic              in_bounds;
  logic [ADDR_W-1:0] addr;

  assign gate_ok   = !GATE_VBLANK || vblank;
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign pix_ready = mode_q && gate_ok && (state == RUN);
  assign step      = (state == RUN) && gate_ok && (!mode_q || pix_valid);

  rect_walker #(
    .FB_W   (FB_W),
    .FB_H   (FB_H),
    .ADDR_W (ADDR_W)
  ) u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .step      (step),
    .x         (x_q),
    .y         (y_q),
    .w         (w_q),
    .h         (h_q),
    .last      (last),
    .in_bounds (in_bounds),
    .addr      (addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q  <= cmd_mode;
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
            if (cmd_w == 8'd0 || cmd_h == 7'd0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (step) begin
            // Clipped positions still consume a step but never write.
            we    <= in_bounds;
            waddr <= addr;
            wdata <= mode_q ? pix_data : color_q;
            if (last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (!gate_ok) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (gate_ok) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_blitter.sv
// Directed plus randomized checks of vram_blitter against a raster-order
// model of the expected VRAM writes.
module tb_vram_blitter;

  logic        clk;
  logic        rst_n;
  logic        vblank;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_mode;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [12:0] cmd_color;
  logic        pix_valid;
  logic        pix_ready;
  logic [12:0] pix_data;
  logic        we;
  logic [14:0] waddr;
  logic [12:0] wdata;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic done_with_we = 1'b0;

  logic [27:0] exp_q[$];
  logic [12:0] stream_q[$];
  int dir_pat [6] = '{1, 0, 1, 1, 0, 1};

  vram_blitter #(.GATE_VBLANK(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblank    (vblank),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: every position of the rectangle in raster order, kept
  // only when it lands inside the framebuffer.
  task automatic model_rect(input int mode, input int x, input int y, input int w,
                            input int h, input logic [12:0] color, output int n_exp);
    int n;
    int addr;
    logic [12:0] d;
    n = 0;
    n_exp = 0;
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        d = (mode == 1) ? stream_q[n] : color;
        n++;
        if ((x + i) < 160 && (y + j) < 120) begin
          addr = (y + j) * 160 + (x + i);
          exp_q.push_back({addr[14:0], d});
          n_exp++;
        end
      end
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write", {4'd0, waddr, wdata}, 32'hFFFF_FFFF);
        else chk("write", {4'd0, waddr, wdata}, {4'd0, exp_q.pop_front()});
      end
      if (done) begin
        done_cnt++;
        done_with_we = we;
        chk("queue_empty_at_done", exp_q.size(), 0);
      end
    end
  end

  // driver tasks
  task automatic send_cmd(input int mode, input int x, input int y, input int w,
                          input int h, input logic [12:0] color, output int n_exp);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 1);
    model_rect(mode, x, y, w, h, color, n_exp);
    cmd_mode  = mode[0];
    cmd_x     = x[7:0];
    cmd_y     = y[6:0];
    cmd_w     = w[7:0];
    cmd_h     = h[6:0];
    cmd_color = color;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed_stream(input int n_pix, input int directed);
    int n;
    int cyc;
    int v;
    logic rdy;
    n = 0;
    cyc = 0;
    while (n < n_pix && cyc < 1000) begin
      v = (directed != 0) ? dir_pat[cyc % 6] : int'($urandom_range(0, 1));
      pix_valid = v[0];
      pix_data  = stream_q[n];
      @(negedge clk);
      rdy = pix_ready;
      chk("pix_ready_in_run", {31'd0, rdy}, 1);
      @(posedge clk);
      if (v != 0 && rdy) n++;
      #1;
      cyc++;
    end
    pix_valid = 1'b0;
    chk("stream_consumed", n, n_pix);
  endtask

  task automatic wait_done(output int cyc);
    logic seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else cyc++;
    end
    #1;
    chk("done_seen", {31'd0, seen}, 1);
  endtask

  initial begin
    int n_exp;
    int cyc;
    int base_w;
    int base_d;
    int n;
    int mode, x, y, w, h;

    rst_n = 1'b0; vblank = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    pix_valid = 1'b0; pix_data = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_pix_ready", {31'd0, pix_ready}, 0);
    chk("rst_we", {31'd0, we}, 0);
    chk("rst_waddr", {17'd0, waddr}, 0);
    chk("rst_wdata", {19'd0, wdata}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // fill 3x2 at (10,5)
    send_cmd(0, 10, 5, 3, 2, 13'h1FFF, n_exp);
    @(negedge clk);
    chk("fill_busy_start", {31'd0, busy}, 1);
    chk("fill_we_start", {31'd0, we}, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("fill_we", {31'd0, we}, 1);
      chk("fill_done", {31'd0, done}, (k == 6) ? 1 : 0);
      chk("fill_busy", {31'd0, busy}, (k < 6) ? 1 : 0);
    end
    #1;
    chk("fill_drained", exp_q.size(), 0);
    chk("fill_done_with_we", {31'd0, done_with_we}, 1);

    // stream 4x1 at origin with a stuttering producer
    stream_q.delete();
    for (int k = 0; k < 4; k++) stream_q.push_back(13'($urandom));
    base_w = wr_cnt;
    send_cmd(1, 0, 0, 4, 1, 13'h0, n_exp);
    feed_stream(4, 1);
    wait_done(cyc);
    chk("stream_done_lat", cyc, 0);
    chk("stream_writes", wr_cnt - base_w, 4);

    // clipped fill at the bottom-right corner
    base_w = wr_cnt;
    send_cmd(0, 158, 119, 4, 2, 13'h0ABC, n_exp);
    wait_done(cyc);
    chk("clip_steps", cyc, 8);
    chk("clip_writes", wr_cnt - base_w, 2);
    chk("clip_done_with_we", {31'd0, done_with_we}, 0);

    // vblank gating
    base_w = wr_cnt;
    base_d = done_cnt;
    send_cmd(0, 40, 30, 5, 1, 13'h1234, n_exp);
    repeat (2) @(posedge clk);
    #1;
    vblank = 1'b0;
    @(negedge clk);
    #1;
    chk("gate_first_writes", wr_cnt - base_w, 2);
    repeat (9) begin
      @(negedge clk);
      chk("hold_we", {31'd0, we}, 0);
      chk("hold_pix_ready", {31'd0, pix_ready}, 0);
      chk("hold_busy", {31'd0, busy}, 1);
    end
    @(posedge clk);
    #1;
    vblank = 1'b1;
    wait_done(cyc);
    chk("gate_writes", wr_cnt - base_w, 5);
    chk("gate_dones", done_cnt - base_d, 1);

    // zero-size command
    base_w = wr_cnt;
    base_d = done_cnt;
    send_cmd(0, 3, 3, 0, 7, 13'h0FFF, n_exp);
    @(negedge clk);
    chk("zero_done", {31'd0, done}, 1);
    chk("zero_we", {31'd0, we}, 0);
    chk("zero_busy", {31'd0, busy}, 0);
    chk("zero_cmd_ready", {31'd0, cmd_ready}, 1);
    @(negedge clk);
    #1;
    chk("zero_done_pulse", {31'd0, done}, 0);
    chk("zero_writes", wr_cnt - base_w, 0);
    chk("zero_dones", done_cnt - base_d, 1);

    // reset in the middle of a 10-word fill
    base_w = wr_cnt;
    base_d = done_cnt;
    send_cmd(0, 0, 10, 10, 1, 13'h0555, n_exp);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((wr_cnt - base_w) < 3 && n < 100);
    chk("abort_three_writes", wr_cnt - base_w, 3);
    rst_n = 1'b0;
    #1;
    chk("abort_we", {31'd0, we}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 1);
    repeat (3) begin
      @(negedge clk);
      chk("abort_we_held", {31'd0, we}, 0);
    end
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt - base_d, 0);
    base_w = wr_cnt;
    send_cmd(0, 20, 20, 3, 1, 13'h1111, n_exp);
    wait_done(cyc);
    chk("after_abort_writes", wr_cnt - base_w, 3);

    // randomized rectangles, some straddling the edges
    for (int t = 0; t < 10; t++) begin
      mode = int'($urandom_range(0, 1));
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 149));
      y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 109));
      w = int'($urandom_range(1, 8));
      h = int'($urandom_range(1, 4));
      stream_q.delete();
      for (int k = 0; k < w * h; k++) stream_q.push_back(13'($urandom));
      base_w = wr_cnt;
      base_d = done_cnt;
      send_cmd(mode, x, y, w, h, 13'($urandom), n_exp);
      if (mode == 1) feed_stream(w * h, 0);
      wait_done(cyc);
      chk("rand_writes", wr_cnt - base_w, n_exp);
      chk("rand_dones", done_cnt - base_d, 1);
    end

    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
